// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap and counter state holder.
// Owns mstatus.MIE/MPIE, mepc, mcause, mtval, mcycle and minstret, performs
// trap entry and mret, and hands the resulting PC redirect to fetch through
// a valid/ready handshake.
module trap_ctrl #(
   parameter int unsigned RESET_PC_UNUSED = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        csr_we,
   input  logic        mie_next,
   input  logic        mpie_next,
   input  logic [31:0] mepc_next,
   input  logic [31:0] mcause_next,
   input  logic [31:0] mtval_next,
   input  logic [63:0] mcycle_next,
   input  logic [63:0] minstret_next,
   input  logic        mcycle_inhibit,
   input  logic        minstret_inhibit,
   input  logic [29:0] mtvec_base,
   input  logic        mtie,
   input  logic        msie,
   input  logic        meie,
   input  logic        mtip,
   input  logic        msip,
   input  logic        meip,
   input  logic        exc_valid,
   input  logic [3:0]  exc_cause,
   input  logic [31:0] exc_pc,
   input  logic [31:0] exc_tval,
   input  logic        mret,
   input  logic        retire,
   input  logic        boundary,
   input  logic [31:0] boundary_pc,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   input  logic        redirect_ready,
   output logic        mie,
   output logic        mpie,
   output logic [31:0] mepc,
   output logic [31:0] mcause,
   output logic [31:0] mtval,
   output logic [63:0] mcycle,
   output logic [63:0] minstret
);

   // Reserved parameter: no behaviour is attached to any value.
   if (RESET_PC_UNUSED != 0) begin : g_reset_pc_reserved
   end

   typedef enum logic {
      S_RUN,
      S_REDIRECT
   } state_t;

   state_t     state;
   logic       irq_pend;
   logic       irq_take;
   logic       csr_acc;
   logic [3:0] irq_code;

   // Interrupt selection and arbitration of csr_we against higher-priority events.
   always_comb begin
      irq_pend = boundary && mie && ((meip && meie) || (msip && msie) || (mtip && mtie));
      irq_code = 4'd7;
      if (meip && meie)
         irq_code = 4'd11;
      else if (msip && msie)
         irq_code = 4'd3;
      irq_take = (state == S_RUN) && !exc_valid && !mret && irq_pend;
      csr_acc  = (state == S_RUN) && csr_we && !exc_valid && !mret && !irq_pend;
   end

   // Trap/return state machine, CSR writes and free-running counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_RUN;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         mie            <= 1'b0;
         mpie           <= 1'b0;
         mepc           <= '0;
         mcause         <= '0;
         mtval          <= '0;
         mcycle         <= '0;
         minstret       <= '0;
      end else begin
         case (state)
            S_RUN: begin
               if (exc_valid) begin
                  mepc           <= {exc_pc[31:2], 2'b00};
                  mcause         <= {28'b0, exc_cause};
                  mtval          <= exc_tval;
                  mpie           <= mie;
                  mie            <= 1'b0;
                  redirect_pc    <= {mtvec_base, 2'b00};
                  redirect_valid <= 1'b1;
                  state          <= S_REDIRECT;
               end else if (mret) begin
                  mie            <= mpie;
                  mpie           <= 1'b1;
                  redirect_pc    <= mepc;
                  redirect_valid <= 1'b1;
                  state          <= S_REDIRECT;
               end else if (irq_take) begin
                  mepc           <= {boundary_pc[31:2], 2'b00};
                  mcause         <= {1'b1, 27'b0, irq_code};
                  mtval          <= '0;
                  mpie           <= mie;
                  mie            <= 1'b0;
                  redirect_pc    <= {mtvec_base, 2'b00};
                  redirect_valid <= 1'b1;
                  state          <= S_REDIRECT;
               end else if (csr_acc) begin
                  mie            <= mie_next;
                  mpie           <= mpie_next;
                  mepc           <= mepc_next;
                  mcause         <= mcause_next;
                  mtval          <= mtval_next;
               end
            end
            S_REDIRECT: begin
               if (redirect_ready) begin
                  redirect_valid <= 1'b0;
                  state          <= S_RUN;
               end
            end
            default: begin
               redirect_valid <= 1'b0;
               state          <= S_RUN;
            end
         endcase

         if (csr_acc) begin
            mcycle   <= mcycle_next;
            minstret <= minstret_next;
         end else begin
            if (!mcycle_inhibit)
               mcycle <= mcycle + 64'd1;
            if (retire && !minstret_inhibit)
               minstret <= minstret + 64'd1;
         end
      end
   end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: table-driven, hand-sequenced and randomized checks of trap_ctrl
// against a behavioural model of the trap/counter rules.
module tb_trap_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        csr_we;
   logic        mie_next, mpie_next;
   logic [31:0] mepc_next, mcause_next, mtval_next;
   logic [63:0] mcycle_next, minstret_next;
   logic        mcycle_inhibit, minstret_inhibit;
   logic [29:0] mtvec_base;
   logic        mtie, msie, meie, mtip, msip, meip;
   logic        exc_valid;
   logic [3:0]  exc_cause;
   logic [31:0] exc_pc, exc_tval;
   logic        mret, retire, boundary;
   logic [31:0] boundary_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        redirect_ready;
   logic        mie, mpie;
   logic [31:0] mepc, mcause, mtval;
   logic [63:0] mcycle, minstret;

   always #5 clk = ~clk;

   trap_ctrl #(.RESET_PC_UNUSED(0)) dut (
      .clk(clk), .rst(rst), .csr_we(csr_we),
      .mie_next(mie_next), .mpie_next(mpie_next),
      .mepc_next(mepc_next), .mcause_next(mcause_next), .mtval_next(mtval_next),
      .mcycle_next(mcycle_next), .minstret_next(minstret_next),
      .mcycle_inhibit(mcycle_inhibit), .minstret_inhibit(minstret_inhibit),
      .mtvec_base(mtvec_base),
      .mtie(mtie), .msie(msie), .meie(meie), .mtip(mtip), .msip(msip), .meip(meip),
      .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
      .mret(mret), .retire(retire), .boundary(boundary), .boundary_pc(boundary_pc),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .redirect_ready(redirect_ready),
      .mie(mie), .mpie(mpie), .mepc(mepc), .mcause(mcause), .mtval(mtval),
      .mcycle(mcycle), .minstret(minstret)
   );

   typedef struct {
      logic        rst;
      logic        csr_we;
      logic        mie_next, mpie_next;
      logic [31:0] mepc_next, mcause_next, mtval_next;
      logic [63:0] mcycle_next, minstret_next;
      logic        mcycle_inhibit, minstret_inhibit;
      logic [29:0] mtvec_base;
      logic        mtie, msie, meie, mtip, msip, meip;
      logic        exc_valid;
      logic [3:0]  exc_cause;
      logic [31:0] exc_pc, exc_tval;
      logic        mret, retire, boundary;
      logic [31:0] boundary_pc;
      logic        redirect_ready;
   } in_t;

   typedef struct {
      in_t         i;
      logic        rv;
      logic [31:0] rpc;
      logic        e_mie, e_mpie;
      logic [31:0] e_mepc, e_mcause, e_mtval;
   } vec_t;

   vec_t tbl[$];

   int checks   = 0;
   int failures = 0;

   // Reference model state
   logic        m_redir;
   logic [31:0] m_rpc;
   logic        m_mie, m_mpie;
   logic [31:0] m_mepc, m_mcause, m_mtval;
   logic [63:0] m_mcycle, m_minstret;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic in_t idle();
      in_t v;
      v = '{default: '0};
      return v;
   endfunction

   task automatic drive(input in_t v);
      rst = v.rst; csr_we = v.csr_we;
      mie_next = v.mie_next; mpie_next = v.mpie_next;
      mepc_next = v.mepc_next; mcause_next = v.mcause_next; mtval_next = v.mtval_next;
      mcycle_next = v.mcycle_next; minstret_next = v.minstret_next;
      mcycle_inhibit = v.mcycle_inhibit; minstret_inhibit = v.minstret_inhibit;
      mtvec_base = v.mtvec_base;
      mtie = v.mtie; msie = v.msie; meie = v.meie;
      mtip = v.mtip; msip = v.msip; meip = v.meip;
      exc_valid = v.exc_valid; exc_cause = v.exc_cause;
      exc_pc = v.exc_pc; exc_tval = v.exc_tval;
      mret = v.mret; retire = v.retire; boundary = v.boundary;
      boundary_pc = v.boundary_pc; redirect_ready = v.redirect_ready;
   endtask

   // Spec-level model: one accepted event per cycle in priority order, counters always.
   task automatic model_step(input in_t v);
      bit          wrote;
      bit          want_irq;
      logic [31:0] code;
      logic        old_mie;
      wrote = 0;
      if (v.rst) begin
         m_redir = 0; m_rpc = 0; m_mie = 0; m_mpie = 0;
         m_mepc = 0; m_mcause = 0; m_mtval = 0; m_mcycle = 0; m_minstret = 0;
         return;
      end
      if (m_redir) begin
         if (v.redirect_ready) m_redir = 0;
      end else begin
         want_irq = v.boundary && m_mie &&
                    ((v.meip && v.meie) || (v.msip && v.msie) || (v.mtip && v.mtie));
         if (v.meip && v.meie)      code = 11;
         else if (v.msip && v.msie) code = 3;
         else                       code = 7;
         old_mie = m_mie;
         if (v.exc_valid) begin
            m_mepc = v.exc_pc & ~32'h3;
            m_mcause = 32'(v.exc_cause);
            m_mtval = v.exc_tval;
            m_mpie = old_mie; m_mie = 0;
            m_rpc = 32'(v.mtvec_base) * 4;
            m_redir = 1;
         end else if (v.mret) begin
            m_mie = m_mpie; m_mpie = 1;
            m_rpc = m_mepc;
            m_redir = 1;
         end else if (want_irq) begin
            m_mepc = v.boundary_pc & ~32'h3;
            m_mcause = 32'h8000_0000 + code;
            m_mtval = 0;
            m_mpie = old_mie; m_mie = 0;
            m_rpc = 32'(v.mtvec_base) * 4;
            m_redir = 1;
         end else if (v.csr_we) begin
            wrote = 1;
            m_mie = v.mie_next; m_mpie = v.mpie_next;
            m_mepc = v.mepc_next; m_mcause = v.mcause_next; m_mtval = v.mtval_next;
            m_mcycle = v.mcycle_next; m_minstret = v.minstret_next;
         end
      end
      if (!wrote) begin
         if (!v.mcycle_inhibit) m_mcycle = m_mcycle + 1;
         if (v.retire && !v.minstret_inhibit) m_minstret = m_minstret + 1;
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, "_redirect_valid"}, 64'(redirect_valid), 64'(m_redir));
      chk({tag, "_redirect_pc"}, 64'(redirect_pc), 64'(m_rpc));
      chk({tag, "_mie"}, 64'(mie), 64'(m_mie));
      chk({tag, "_mpie"}, 64'(mpie), 64'(m_mpie));
      chk({tag, "_mepc"}, 64'(mepc), 64'(m_mepc));
      chk({tag, "_mcause"}, 64'(mcause), 64'(m_mcause));
      chk({tag, "_mtval"}, 64'(mtval), 64'(m_mtval));
      chk({tag, "_mcycle"}, mcycle, m_mcycle);
      chk({tag, "_minstret"}, minstret, m_minstret);
   endtask

   task automatic step(input in_t v, input string tag);
      drive(v);
      model_step(v);
      @(posedge clk);
      #1;
      check_model(tag);
   endtask

   task automatic add(input in_t i, input logic rv, input logic [31:0] rpc,
                      input logic e_mie, input logic e_mpie,
                      input logic [31:0] e_mepc, input logic [31:0] e_mcause,
                      input logic [31:0] e_mtval);
      vec_t t;
      t.i = i; t.rv = rv; t.rpc = rpc; t.e_mie = e_mie; t.e_mpie = e_mpie;
      t.e_mepc = e_mepc; t.e_mcause = e_mcause; t.e_mtval = e_mtval;
      tbl.push_back(t);
   endtask

   function automatic in_t rnd_in();
      in_t v;
      v = idle();
      v.rst = ($urandom_range(0, 63) == 0);
      v.csr_we = ($urandom_range(0, 3) == 0);
      v.mie_next = 1'($urandom); v.mpie_next = 1'($urandom);
      v.mepc_next = $urandom; v.mcause_next = $urandom; v.mtval_next = $urandom;
      if ($urandom_range(0, 3) == 0)
         v.mcycle_next = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 3));
      else
         v.mcycle_next = {$urandom, $urandom};
      v.minstret_next = {$urandom, 32'hFFFF_FFFF - 32'($urandom_range(0, 3))};
      v.mcycle_inhibit = ($urandom_range(0, 7) == 0);
      v.minstret_inhibit = ($urandom_range(0, 7) == 0);
      v.mtvec_base = 30'($urandom);
      v.mtie = 1'($urandom); v.msie = 1'($urandom); v.meie = 1'($urandom);
      v.mtip = 1'($urandom); v.msip = 1'($urandom); v.meip = 1'($urandom);
      v.exc_valid = ($urandom_range(0, 7) == 0);
      v.exc_cause = 4'($urandom);
      v.exc_pc = $urandom; v.exc_tval = $urandom;
      v.mret = ($urandom_range(0, 7) == 0);
      v.retire = 1'($urandom);
      v.boundary = 1'($urandom);
      v.boundary_pc = $urandom;
      v.redirect_ready = 1'($urandom);
      return v;
   endfunction

   initial begin
      in_t v;

      // ---- Vector table: {inputs, expected state after the edge} ----
      v = idle(); v.csr_we = 1; v.mie_next = 1;
      add(v, 0, 32'h0, 1, 0, 32'h0, 32'h0, 32'h0);
      v = idle(); v.mtvec_base = 30'h100; v.exc_valid = 1; v.exc_cause = 4'd2;
      v.exc_pc = 32'h87; v.exc_tval = 32'hDEAD;
      add(v, 1, 32'h400, 0, 1, 32'h84, 32'h2, 32'hDEAD);
      for (int k = 0; k < 3; k++) begin
         v = idle(); v.exc_valid = 1; v.exc_cause = 4'd9; v.exc_pc = 32'h999;
         v.mret = 1; v.csr_we = 1; v.mtvec_base = 30'h3; v.redirect_ready = 0;
         add(v, 1, 32'h400, 0, 1, 32'h84, 32'h2, 32'hDEAD);
      end
      v = idle(); v.redirect_ready = 1;
      add(v, 0, 32'h400, 0, 1, 32'h84, 32'h2, 32'hDEAD);
      v = idle(); v.csr_we = 1; v.mie_next = 1; v.mpie_next = 0;
      v.mepc_next = 32'h84; v.mcause_next = 32'h2; v.mtval_next = 32'hDEAD;
      add(v, 0, 32'h400, 1, 0, 32'h84, 32'h2, 32'hDEAD);
      v = idle(); v.mtvec_base = 30'h100; v.meie = 1; v.msie = 1; v.mtie = 1;
      v.meip = 1; v.msip = 1; v.mtip = 1; v.boundary = 1; v.boundary_pc = 32'h200;
      add(v, 1, 32'h400, 0, 1, 32'h200, 32'h8000_000B, 32'h0);
      v = idle(); v.redirect_ready = 1;
      add(v, 0, 32'h400, 0, 1, 32'h200, 32'h8000_000B, 32'h0);
      v = idle(); v.mtvec_base = 30'h100; v.meie = 1; v.msie = 1; v.mtie = 1;
      v.meip = 1; v.msip = 1; v.mtip = 1; v.boundary = 1; v.boundary_pc = 32'h200;
      add(v, 0, 32'h400, 0, 1, 32'h200, 32'h8000_000B, 32'h0);
      v = idle(); v.csr_we = 1; v.mie_next = 1; v.mpie_next = 1; v.mepc_next = 32'h300;
      add(v, 0, 32'h400, 1, 1, 32'h300, 32'h0, 32'h0);
      v = idle(); v.exc_valid = 1; v.mret = 1; v.exc_cause = 4'd5;
      v.exc_pc = 32'h1000; v.exc_tval = 32'h11; v.mtvec_base = 30'h100;
      add(v, 1, 32'h400, 0, 1, 32'h1000, 32'h5, 32'h11);
      v = idle(); v.redirect_ready = 1;
      add(v, 0, 32'h400, 0, 1, 32'h1000, 32'h5, 32'h11);
      v = idle(); v.mret = 1;
      add(v, 1, 32'h1000, 1, 1, 32'h1000, 32'h5, 32'h11);
      v = idle(); v.redirect_ready = 1;
      add(v, 0, 32'h1000, 1, 1, 32'h1000, 32'h5, 32'h11);
      v = idle(); v.mtvec_base = 30'h100; v.msie = 1; v.msip = 1; v.mtie = 1; v.mtip = 1;
      v.meie = 1; v.boundary = 1; v.boundary_pc = 32'h203;
      add(v, 1, 32'h400, 0, 1, 32'h200, 32'h8000_0003, 32'h0);
      v = idle(); v.redirect_ready = 1;
      add(v, 0, 32'h400, 0, 1, 32'h200, 32'h8000_0003, 32'h0);
      v = idle(); v.mret = 1; v.redirect_ready = 1;
      add(v, 1, 32'h200, 1, 1, 32'h200, 32'h8000_0003, 32'h0);
      v = idle(); v.redirect_ready = 1;
      add(v, 0, 32'h200, 1, 1, 32'h200, 32'h8000_0003, 32'h0);
      v = idle(); v.mtie = 1; v.mtip = 1; v.boundary = 0; v.boundary_pc = 32'h40;
      add(v, 0, 32'h200, 1, 1, 32'h200, 32'h8000_0003, 32'h0);
      v = idle(); v.mtvec_base = 30'h100; v.mtie = 1; v.mtip = 1;
      v.boundary = 1; v.boundary_pc = 32'h40;
      add(v, 1, 32'h400, 0, 1, 32'h40, 32'h8000_0007, 32'h0);
      v = idle(); v.redirect_ready = 1;
      add(v, 0, 32'h400, 0, 1, 32'h40, 32'h8000_0007, 32'h0);

      // ---- Reset ----
      v = idle(); v.rst = 1;
      step(v, "rst0");
      step(v, "rst1");
      chk("rst_redirect_valid", 64'(redirect_valid), 64'h0);
      chk("rst_redirect_pc", 64'(redirect_pc), 64'h0);
      chk("rst_mie", 64'(mie), 64'h0);
      chk("rst_mpie", 64'(mpie), 64'h0);
      chk("rst_mepc", 64'(mepc), 64'h0);
      chk("rst_mcause", 64'(mcause), 64'h0);
      chk("rst_mtval", 64'(mtval), 64'h0);
      chk("rst_mcycle", mcycle, 64'h0);
      chk("rst_minstret", minstret, 64'h0);
      v = idle();
      step(v, "rel");
      chk("rel_mcycle", mcycle, 64'h1);

      // ---- Table ----
      for (int k = 0; k < tbl.size(); k++) begin
         step(tbl[k].i, $sformatf("tblm%0d", k));
         chk($sformatf("tbl%0d_redirect_valid", k), 64'(redirect_valid), 64'(tbl[k].rv));
         chk($sformatf("tbl%0d_redirect_pc", k), 64'(redirect_pc), 64'(tbl[k].rpc));
         chk($sformatf("tbl%0d_mie", k), 64'(mie), 64'(tbl[k].e_mie));
         chk($sformatf("tbl%0d_mpie", k), 64'(mpie), 64'(tbl[k].e_mpie));
         chk($sformatf("tbl%0d_mepc", k), 64'(mepc), 64'(tbl[k].e_mepc));
         chk($sformatf("tbl%0d_mcause", k), 64'(mcause), 64'(tbl[k].e_mcause));
         chk($sformatf("tbl%0d_mtval", k), 64'(mtval), 64'(tbl[k].e_mtval));
      end

      // ---- Counter corners ----
      v = idle(); v.csr_we = 1; v.mcycle_next = 64'h0000_0000_FFFF_FFFF; v.minstret_next = 64'h10;
      step(v, "cnt_wr");
      chk("cnt_wr_mcycle", mcycle, 64'h0000_0000_FFFF_FFFF);
      v = idle();
      step(v, "cnt_carry");
      chk("cnt_carry_mcycle", mcycle, 64'h0000_0001_0000_0000);
      v = idle(); v.csr_we = 1; v.mcycle_next = 64'd5; v.minstret_next = 64'h77; v.retire = 1;
      step(v, "cnt_wins");
      chk("cnt_wins_mcycle", mcycle, 64'd5);
      chk("cnt_wins_minstret", minstret, 64'h77);
      v = idle(); v.retire = 1; v.minstret_inhibit = 1;
      step(v, "cnt_inh");
      chk("cnt_inh_minstret", minstret, 64'h77);
      chk("cnt_inh_mcycle", mcycle, 64'd6);
      v = idle(); v.retire = 1; v.mcycle_inhibit = 1;
      step(v, "cnt_ret");
      chk("cnt_ret_minstret", minstret, 64'h78);
      chk("cnt_ret_mcycle", mcycle, 64'd6);
      v = idle(); v.csr_we = 1; v.mcycle_next = 64'hFFFF_FFFF_FFFF_FFFF;
      v.minstret_next = 64'hFFFF_FFFF_FFFF_FFFF;
      step(v, "cnt_max");
      v = idle(); v.retire = 1;
      step(v, "cnt_wrap");
      chk("cnt_wrap_mcycle", mcycle, 64'h0);
      chk("cnt_wrap_minstret", minstret, 64'h0);

      // ---- Reset during REDIRECT ----
      v = idle(); v.exc_valid = 1; v.exc_cause = 4'd4; v.exc_pc = 32'h123;
      v.exc_tval = 32'h5; v.mtvec_base = 30'h10;
      step(v, "rr_exc");
      chk("rr_exc_redirect_valid", 64'(redirect_valid), 64'h1);
      chk("rr_exc_redirect_pc", 64'(redirect_pc), 64'h40);
      v = idle(); v.rst = 1;
      step(v, "rr_rst");
      chk("rr_rst_redirect_valid", 64'(redirect_valid), 64'h0);
      chk("rr_rst_redirect_pc", 64'(redirect_pc), 64'h0);
      chk("rr_rst_mepc", 64'(mepc), 64'h0);
      chk("rr_rst_mcause", 64'(mcause), 64'h0);
      chk("rr_rst_mtval", 64'(mtval), 64'h0);
      chk("rr_rst_mcycle", mcycle, 64'h0);
      v = idle(); v.exc_valid = 1; v.exc_cause = 4'd6; v.exc_pc = 32'h80; v.mtvec_base = 30'h20;
      step(v, "rr_again");
      chk("rr_again_redirect_valid", 64'(redirect_valid), 64'h1);
      chk("rr_again_redirect_pc", 64'(redirect_pc), 64'h80);
      chk("rr_again_mcause", 64'(mcause), 64'h6);
      v = idle(); v.redirect_ready = 1;
      step(v, "rr_done");
      chk("rr_done_redirect_valid", 64'(redirect_valid), 64'h0);

      // ---- Randomized run against the model ----
      for (int n = 0; n < 3000; n++) begin
         step(rnd_in(), "rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
